mem_loader: RTL and testbench

Program-image loader between an external byte stream and the on-chip `memory` block. After reset it holds the `cpu` in reset, takes a length-prefixed byte image from a valid/ready stream, and packs it little-endian into 16-bit words written from address 0. When the image is complete it hands the memory port to the `cpu` and releases the CPU reset. It replaces the simulation-only `$fread` preload with a synthesizable boot path.

---
 rtl/mem_loader.sv | 189 ++++++++++++++++++
 tb/tb_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader
//   Boot-time program-image loader. Holds the CPU in reset and receives a
//   length-prefixed byte image from a valid/ready stream. Packs the image
//   little-endian into 16-bit words written from address 0. When the image is
//   complete, hands the memory port to the CPU and releases its reset.
//
// Stream handshake: a byte moves when s_valid && s_ready are both high at a
//   rising clk edge. s_data is ignored while s_valid is low. s_ready depends
//   only on the loader state (and is forced low while rst_n is low). It never
//   depends on s_valid.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   s_data/s_valid/s_ready     image byte stream (LEN_LO, LEN_HI, payload)
//   i_reload                   one-cycle pulse; restarts loading from DONE
//   i_cpu_*                    CPU memory request, passed through in DONE
//   o_mem_*                    memory port (loader in load, CPU in DONE)
//   o_cpu_rst                  active-high CPU reset
//   o_done                     image loaded, CPU owns memory
//   o_err                      image longer than memory capacity
//   dbg_state                  current FSM state, for observation
module mem_loader #(
  parameter int MEM_DEPTH  = 2**12,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  i_reload,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic                  i_cpu_en,
  input  logic                  i_cpu_rd_en,
  input  logic [1:0]            i_cpu_wr_en,
  input  logic [15:0]           i_cpu_di,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  output logic [1:0]            o_mem_wr_en,
  output logic [15:0]           o_mem_di,
  output logic                  o_cpu_rst,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Byte capacity of the memory; byte indices at or above this are dropped.
  localparam logic [31:0] CAP = 32'(MEM_DEPTH * 2);

  state_t                state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [15:0]           byte_idx;   // index of the next payload byte
  logic [7:0]            lo_byte;
  logic                  last_word;
  logic                  ld_en;
  logic [1:0]            ld_wr_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [15:0]           ld_di;

  logic xfer;
  logic in_range;
  logic is_last;

  assign s_ready  = rst_n && (state == S_LEN_LO || state == S_LEN_HI ||
                              state == S_DATA_LO || state == S_DATA_HI);
  assign xfer     = s_valid && s_ready;
  assign in_range = {16'd0, byte_idx} < CAP;
  assign is_last  = (byte_idx == len - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LEN_LO;
      len_lo    <= '0;
      len       <= '0;
      byte_idx  <= '0;
      lo_byte   <= '0;
      last_word <= 1'b0;
      ld_en     <= 1'b0;
      ld_wr_en  <= '0;
      ld_addr   <= '0;
      ld_di     <= '0;
      o_cpu_rst <= 1'b1;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      // Write-port registers are only non-zero for the single WRITE cycle.
      ld_en    <= 1'b0;
      ld_wr_en <= '0;
      ld_addr  <= '0;
      ld_di    <= '0;
      case (state)
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= s_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len      <= {s_data, len_lo};
            byte_idx <= '0;
            if ({s_data, len_lo} == 16'd0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            byte_idx <= byte_idx + 16'd1;
            lo_byte  <= s_data;
            if (!in_range) o_err <= 1'b1;
            if (is_last) begin
              // Final odd byte: low lane only, high byte forced to zero.
              state     <= S_WRITE;
              last_word <= 1'b1;
              if (in_range) begin
                ld_en    <= 1'b1;
                ld_wr_en <= 2'b01;
                ld_addr  <= byte_idx[ADDR_WIDTH-1:0];
                ld_di    <= {8'h00, s_data};
              end
            end else begin
              state     <= S_DATA_HI;
              last_word <= 1'b0;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            byte_idx  <= byte_idx + 16'd1;
            state     <= S_WRITE;
            last_word <= is_last;
            if (!in_range) o_err <= 1'b1;
            // Capacity is even, so both bytes of a word share range status.
            if (in_range) begin
              ld_en    <= 1'b1;
              ld_wr_en <= 2'b11;
              ld_addr  <= {byte_idx[ADDR_WIDTH-1:1], 1'b0};
              ld_di    <= {s_data, lo_byte};
            end
          end
        end
        S_WRITE: begin
          if (last_word) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            state <= S_DATA_LO;
          end
        end
        S_DONE: begin
          // CPU reset drops one cycle after o_done so the last write has landed.
          if (o_done) o_cpu_rst <= 1'b0;
          if (i_reload) begin
            state     <= S_LEN_LO;
            o_done    <= 1'b0;
            o_cpu_rst <= 1'b1;
            o_err     <= 1'b0;
          end
        end
        default: state <= S_LEN_LO;
      endcase
    end
  end

  // Memory port: CPU owns it in DONE, loader registers otherwise.
  assign o_mem_addr  = (state == S_DONE) ? i_cpu_addr  : ld_addr;
  assign o_mem_en    = (state == S_DONE) ? i_cpu_en    : ld_en;
  assign o_mem_rd_en = (state == S_DONE) ? i_cpu_rd_en : 1'b0;
  assign o_mem_wr_en = (state == S_DONE) ? i_cpu_wr_en : ld_wr_en;
  assign o_mem_di    = (state == S_DONE) ? i_cpu_di    : ld_di;

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader. The expected memory writes of each image are
// derived from the byte list with plain arithmetic and queued; a monitor pops
// and compares whenever the loader drives a write.
module tb_mem_loader;

  localparam int TB_DEPTH = 16;
  localparam int AW       = $clog2(TB_DEPTH * 2);
  localparam int CAP      = TB_DEPTH * 2;
  localparam int W        = AW + 18;

  logic          clk;
  logic          rst_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          i_reload;
  logic [AW-1:0] i_cpu_addr;
  logic          i_cpu_en;
  logic          i_cpu_rd_en;
  logic [1:0]    i_cpu_wr_en;
  logic [15:0]   i_cpu_di;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_en;
  logic          o_mem_rd_en;
  logic [1:0]    o_mem_wr_en;
  logic [15:0]   o_mem_di;
  logic          o_cpu_rst;
  logic          o_done;
  logic          o_err;
  logic [2:0]    dbg_state;

  logic [W-1:0] exp_q[$];
  logic [7:0]   img_q[$];
  int           wr_cyc_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  mem_loader #(.MEM_DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .i_reload(i_reload),
    .i_cpu_addr(i_cpu_addr), .i_cpu_en(i_cpu_en), .i_cpu_rd_en(i_cpu_rd_en),
    .i_cpu_wr_en(i_cpu_wr_en), .i_cpu_di(i_cpu_di),
    .o_mem_addr(o_mem_addr), .o_mem_en(o_mem_en), .o_mem_rd_en(o_mem_rd_en),
    .o_mem_wr_en(o_mem_wr_en), .o_mem_di(o_mem_di),
    .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_err(o_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h need %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && !o_done) begin
      if (o_mem_en || o_mem_wr_en != 2'b00) begin
        total++;
        wr_cyc_q.push_back(cyc);
        if (s_ready) begin
          bad++;
          $display("FAIL s_ready_in_write: got 1 need 0");
        end
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr %0h we %0b di %0h", o_mem_addr, o_mem_wr_en, o_mem_di);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({o_mem_addr, o_mem_wr_en, o_mem_di} !== e || !o_mem_en || o_mem_rd_en) begin
            bad++;
            $display("FAIL write: got addr %0h we %0b di %0h en %0b rd %0b need addr %0h we %0b di %0h en 1 rd 0",
                     o_mem_addr, o_mem_wr_en, o_mem_di, o_mem_en, o_mem_rd_en,
                     e[W-1:18], e[17:16], e[15:0]);
          end
        end
      end else begin
        check("idle_port_zero", {o_mem_rd_en, o_mem_addr, o_mem_di}, 0);
      end
    end
  end

  // ---------------- reference model ----------------
  // Byte k goes to byte address k; words are pairs (k, k+1) with k even.
  // A word is written once its last byte has been sent, and only if k < CAP.
  task automatic model_image(input int n_send);
    int            n;
    int            last;
    logic [15:0]   di;
    logic [1:0]    we;
    logic [AW-1:0] a;
    n = img_q.size();
    for (int k = 0; k < n; k += 2) begin
      last = (k + 1 < n) ? k + 1 : k;
      if (last < n_send && k < CAP) begin
        di = {((k + 1 < n) ? img_q[k + 1] : 8'h00), img_q[k]};
        we = (k + 1 < n) ? 2'b11 : 2'b01;
        a  = k[AW-1:0];
        exp_q.push_back({a, we, di});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      @(negedge clk);
    end
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL s_ready_timeout: got 0 need 1");
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_image(input int gap_max, input int n_send);
    int n;
    n = img_q.size();
    model_image(n_send);
    send_byte(n[7:0], gap_max);
    send_byte(n[15:8], gap_max);
    for (int i = 0; i < n_send; i++) send_byte(img_q[i], gap_max);
  endtask

  task automatic finish_image(input string tag);
    int n;
    n = img_q.size();
    if (n > 0) begin
      check({tag, "_done_before"}, o_done, 0);
      check({tag, "_ready_write"}, s_ready, 0);
      @(negedge clk);
    end
    check({tag, "_done_rise"}, o_done, 1);
    check({tag, "_cpu_rst_hold"}, o_cpu_rst, 1);
    check({tag, "_err"}, o_err, (n > CAP) ? 1 : 0);
    @(negedge clk);
    check({tag, "_cpu_rst_fall"}, o_cpu_rst, 0);
    check({tag, "_ready_done"}, s_ready, 0);
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reload();
    i_reload = 1'b1;
    @(negedge clk);
    i_reload = 1'b0;
    check("reload_done", o_done, 0);
    check("reload_cpu_rst", o_cpu_rst, 1);
    check("reload_err", o_err, 0);
    check("reload_ready", s_ready, 1);
  endtask

  task automatic cpu_req(input logic [AW-1:0] a, input logic en, input logic rd,
                         input logic [1:0] we, input logic [15:0] di);
    i_cpu_addr = a; i_cpu_en = en; i_cpu_rd_en = rd; i_cpu_wr_en = we; i_cpu_di = di;
    #1;
    check("cpu_addr", o_mem_addr, a);
    check("cpu_en", o_mem_en, en);
    check("cpu_rd", o_mem_rd_en, rd);
    check("cpu_we", o_mem_wr_en, we);
    check("cpu_di", o_mem_di, di);
  endtask

  // CPU keeps requesting during loads; the loader must ignore it.
  task automatic cpu_noise();
    i_cpu_addr  = AW'($urandom);
    i_cpu_en    = 1'b1;
    i_cpu_rd_en = 1'b1;
    i_cpu_wr_en = 2'b11;
    i_cpu_di    = 16'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, s_ready, 0);
    check({tag, "_cpu_rst"}, o_cpu_rst, 1);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_mem"}, {o_mem_en, o_mem_rd_en, o_mem_wr_en, o_mem_addr, o_mem_di}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; i_reload = 1'b0;
    cpu_noise();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", s_ready, 1);
    @(negedge clk);

    // N=4, back-to-back: 0x2211 @0, 0x4433 @2, 3 cycles per word
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_cyc_q.delete();
    send_image(0, 4);
    finish_image("n4");
    check("n4_write_count", wr_cyc_q.size(), 2);
    if (wr_cyc_q.size() == 2) check("n4_word_spacing", wr_cyc_q[1] - wr_cyc_q[0], 3);

    // CPU owns the port in DONE
    cpu_req(5'h10, 1'b1, 1'b0, 2'b10, 16'hBEEF);
    cpu_req(AW'($urandom), 1'b1, 1'b1, 2'b00, 16'($urandom));
    cpu_noise();
    do_reload();

    // N=3, odd tail on low lane only
    img_q = '{8'hAA, 8'hBB, 8'hCC};
    send_image(0, 3);
    finish_image("n3");
    do_reload();

    // N=0, straight to DONE
    img_q.delete();
    send_image(0, 0);
    finish_image("n0");
    do_reload();

    // N=40 over a 32-byte memory
    img_q.delete();
    for (int i = 0; i < 40; i++) img_q.push_back(8'($urandom));
    send_image(0, 40);
    finish_image("over");
    do_reload();

    // N=4 with random valid gaps
    img_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_image(3, 4);
    finish_image("gaps");
    do_reload();

    // random images around the capacity boundary
    for (int t = 0; t < 5; t++) begin
      int n;
      n = int'($urandom_range(40, 0));
      img_q.delete();
      for (int i = 0; i < n; i++) img_q.push_back(8'($urandom));
      send_image(2, n);
      finish_image("rand");
      do_reload();
    end

    // async reset after 3 of 8 payload bytes
    img_q.delete();
    for (int i = 0; i < 8; i++) img_q.push_back(8'($urandom));
    send_image(1, 3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_writes_left", exp_q.size(), 0);
    #1;
    check("midreset_ready", s_ready, 1);
    @(negedge clk);
    img_q = '{8'h5A, 8'hA5, 8'h01, 8'h02, 8'h03};
    send_image(0, 5);
    finish_image("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout need finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
